// File: rtl/mb_uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO.
// Frame: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
module mb_uart_tx_param #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              data_f,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic              send_finish,
    output logic              uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C    = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] DIV_PENULT = 16'(CLK_DIV - 2);
    localparam logic [2:0]  LAST_BIT   = 3'(DATA_W - 1);
    localparam logic        STOP_LAST  = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              par_next;
    logic [15:0]       div_cnt;
    logic [2:0]        bit_idx;
    logic              stop_idx;
    logic              bit_end;
    logic              last_stop;
    logic              push;
    logic              pop;

    // Handshake decode: a pop happens whenever the FSM is ready to start a frame and data waits.
    always_comb begin
        head       = mem[rd_ptr];
        par_next   = (PARITY == 1) ? ~(^head) : ^head;
        bit_end    = (div_cnt == DIV_LAST);
        last_stop  = bit_end && (stop_idx == STOP_LAST);
        push       = data_f && !full;
        pop        = (count != '0) &&
                     ((state == IDLE) || ((state == STOP) && last_stop));
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers, level, and the registered full/overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            full     <= (count_next == DEPTH_C);
            overflow <= data_f && full;
        end
    end

    // Frame sequencer: every bit lasts CLK_DIV clocks; all line-side outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            uart_tx     <= 1'b1;
            busy        <= 1'b0;
            send_finish <= 1'b0;
            div_cnt     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shift       <= '0;
            par_bit     <= 1'b0;
        end else begin
            send_finish <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    div_cnt <= '0;
                    if (pop) begin
                        shift   <= head;
                        par_bit <= par_next;
                        state   <= START;
                        uart_tx <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        uart_tx <= shift[0];
                        div_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            if (PARITY != 0) begin
                                state   <= PAR;
                                uart_tx <= par_bit;
                            end else begin
                                state    <= STOP;
                                uart_tx  <= 1'b1;
                                stop_idx <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state    <= STOP;
                        uart_tx  <= 1'b1;
                        stop_idx <= 1'b0;
                        div_cnt  <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if ((div_cnt == DIV_PENULT) && (stop_idx == STOP_LAST)) begin
                        send_finish <= 1'b1;
                    end
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            if (pop) begin
                                shift   <= head;
                                par_bit <= par_next;
                                state   <= START;
                                uart_tx <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb_uart_tx_param.sv
// Scoreboard bench for mb_uart_tx_param: four instances cover 8N1, even/odd parity and 7-bit two-stop frames.
module tb_mb_uart_tx_param;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] wr;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic [3:0] full, ovf, busy, sf, tx;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$], q1[$], q2[$], q3[$];

    int   sf_cnt[4]   = '{default: 0};
    int   busy_cnt[4] = '{default: 0};
    int   fall_cnt[4] = '{default: 0};
    logic [3:0] prev_busy = '0;

    mb_uart_tx_param #(.CLK_DIV(4)) u0 (
        .clk(clk), .rst_n(rst_n), .data(d0), .data_f(wr[0]), .full(full[0]),
        .overflow(ovf[0]), .busy(busy[0]), .send_finish(sf[0]), .uart_tx(tx[0]));

    mb_uart_tx_param #(.CLK_DIV(4), .PARITY(2)) u1 (
        .clk(clk), .rst_n(rst_n), .data(d1), .data_f(wr[1]), .full(full[1]),
        .overflow(ovf[1]), .busy(busy[1]), .send_finish(sf[1]), .uart_tx(tx[1]));

    mb_uart_tx_param #(.CLK_DIV(4), .PARITY(1)) u2 (
        .clk(clk), .rst_n(rst_n), .data(d2), .data_f(wr[2]), .full(full[2]),
        .overflow(ovf[2]), .busy(busy[2]), .send_finish(sf[2]), .uart_tx(tx[2]));

    mb_uart_tx_param #(.CLK_DIV(3), .DATA_W(7), .PARITY(1), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .data(d3), .data_f(wr[3]), .full(full[3]),
        .overflow(ovf[3]), .busy(busy[3]), .send_finish(sf[3]), .uart_tx(tx[3]));

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running counters of send_finish pulses, busy-high cycles and busy falling edges
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sf[i] === 1'b1) sf_cnt[i] = sf_cnt[i] + 1;
            if (busy[i] === 1'b1) busy_cnt[i] = busy_cnt[i] + 1;
            if (prev_busy[i] === 1'b1 && busy[i] === 1'b0) fall_cnt[i] = fall_cnt[i] + 1;
        end
        prev_busy = busy;
    end

    function automatic int cfg_cd(input int i);
        return (i == 3) ? 3 : 4;
    endfunction

    function automatic logic [15:0] frame_8n1(input logic [7:0] v);
        return {6'b0, 1'b1, v, 1'b0};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int i, input logic [15:0] bits, input int len);
        exp_t e;
        e.bits = bits;
        e.len  = len;
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit found);
        found  = 1'b0;
        e.bits = '0;
        e.len  = 0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); found = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); found = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); found = 1'b1; end
        endcase
    endtask

    // Line monitor: decodes each frame, checks bit values, bit stability, busy and send_finish placement
    task automatic monitor(input int i);
        exp_t        e;
        bit          found, aborted, stable, sf_ok, busy_ok;
        logic [15:0] got;
        int          cd;
        cd = cfg_cd(i);
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx[i] === 1'b0) begin
                pop_exp(i, e, found);
                if (!found) begin
                    check_output($sformatf("unexpected_frame_%0d", i), 32'd1, 32'd0);
                    for (int n = 0; n < 200 && tx[i] === 1'b0; n++) @(negedge clk);
                end else begin
                    aborted = 1'b0;
                    stable  = 1'b1;
                    sf_ok   = 1'b1;
                    busy_ok = 1'b1;
                    got     = '0;
                    for (int k = 0; k < e.len && !aborted; k++) begin
                        for (int c = 0; c < cd && !aborted; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (rst_n !== 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                if (c == 0) got[k] = tx[i];
                                else if (tx[i] !== got[k]) stable = 1'b0;
                                if (sf[i] !== ((k == e.len - 1) && (c == cd - 1))) sf_ok = 1'b0;
                                if (busy[i] !== 1'b1) busy_ok = 1'b0;
                            end
                        end
                    end
                    if (!aborted) begin
                        check_output($sformatf("frame_bits_%0d", i), got, e.bits);
                        check_output($sformatf("bit_stable_%0d", i), stable, 1);
                        check_output($sformatf("send_finish_pos_%0d", i), sf_ok, 1);
                        check_output($sformatf("busy_in_frame_%0d", i), busy_ok, 1);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);

    // Drives one write strobe; the caller advances the clock
    task automatic apply_stimulus(input int i, input logic [7:0] v);
        case (i)
            0: d0 = v;
            1: d1 = v;
            2: d2 = v;
            default: d3 = v[6:0];
        endcase
        wr[i] = 1'b1;
    endtask

    task automatic wait_idle(input int i, input int limit);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < limit) begin
            @(negedge clk);
            n = n + 1;
            if (busy[i] === 1'b0) quiet = quiet + 1;
            else quiet = 0;
        end
        check_output($sformatf("idle_reached_%0d", i), (n < limit), 1);
    endtask

    task automatic wait_sf(input int i, input int limit);
        int n = 0;
        while (sf[i] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n = n + 1;
        end
        check_output($sformatf("send_finish_seen_%0d", i), (n < limit), 1);
    endtask

    // Safety net in case a bounded wait is defeated
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        int s_sf, s_busy, s_fall, lows;
        logic [7:0] bytes4 [4] = '{8'h11, 8'hC3, 8'h7E, 8'h00};
        logic [7:0] bytes6 [6] = '{8'h01, 8'h80, 8'hFF, 8'h5A, 8'h96, 8'h3C};
        logic [7:0] cbytes [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        logic exp_full [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        wr    = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) @(negedge clk);
        check_output("reset_tx", tx, 4'hF);
        check_output("reset_busy", busy, 4'h0);
        check_output("reset_sf", sf, 4'h0);
        check_output("reset_full", full, 4'h0);
        check_output("reset_ovf", ovf, 4'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 frame of 8'h84 with one-clock start latency
        s_sf = sf_cnt[0]; s_busy = busy_cnt[0];
        push_exp(0, 16'h0308, 10);
        apply_stimulus(0, 8'h84);
        @(negedge clk);
        wr[0] = 1'b0;
        check_output("latency_tx_e0", tx[0], 1);
        check_output("latency_busy_e0", busy[0], 0);
        @(negedge clk);
        check_output("latency_tx_e1", tx[0], 0);
        check_output("latency_busy_e1", busy[0], 1);
        wait_idle(0, 100);
        check_output("sf_count_84", sf_cnt[0] - s_sf, 1);
        check_output("busy_cycles_84", busy_cnt[0] - s_busy, 40);

        // Parity and two-stop variants, sent concurrently
        push_exp(1, 16'h0508, 11);
        push_exp(2, 16'h0708, 11);
        push_exp(3, 16'h07AA, 11);
        s_busy = busy_cnt[3];
        apply_stimulus(1, 8'h84);
        apply_stimulus(2, 8'h84);
        apply_stimulus(3, 8'h55);
        @(negedge clk);
        wr = '0;
        wait_idle(1, 100);
        wait_idle(2, 100);
        wait_idle(3, 100);
        check_output("busy_cycles_7o2", busy_cnt[3] - s_busy, 33);

        // Four back-to-back writes: contiguous frames
        s_sf = sf_cnt[0]; s_busy = busy_cnt[0]; s_fall = fall_cnt[0];
        for (int k = 0; k < 4; k++) begin
            push_exp(0, frame_8n1(bytes4[k]), 10);
            apply_stimulus(0, bytes4[k]);
            @(negedge clk);
            check_output($sformatf("b2b_ovf_%0d", k), ovf[0], 0);
            check_output($sformatf("b2b_full_%0d", k), full[0], 0);
        end
        wr[0] = 1'b0;
        wait_idle(0, 300);
        check_output("b2b_sf_count", sf_cnt[0] - s_sf, 4);
        check_output("b2b_busy_cycles", busy_cnt[0] - s_busy, 160);
        check_output("b2b_busy_falls", fall_cnt[0] - s_fall, 1);

        // Six consecutive writes: the sixth is dropped
        s_sf = sf_cnt[0];
        for (int k = 0; k < 6; k++) begin
            if (k < 5) push_exp(0, frame_8n1(bytes6[k]), 10);
            apply_stimulus(0, bytes6[k]);
            @(negedge clk);
            check_output($sformatf("ovf_seq_full_%0d", k), full[0], exp_full[k]);
            check_output($sformatf("ovf_seq_ovf_%0d", k), ovf[0], exp_ovf[k]);
        end
        wr[0] = 1'b0;
        @(negedge clk);
        check_output("ovf_pulse_end", ovf[0], 0);
        check_output("ovf_full_hold", full[0], 1);
        wait_idle(0, 400);
        check_output("ovf_sf_count", sf_cnt[0] - s_sf, 5);

        // Push on the same edge as a pop at level 2
        for (int k = 0; k < 3; k++) begin
            push_exp(0, frame_8n1(cbytes[k]), 10);
            apply_stimulus(0, cbytes[k]);
            @(negedge clk);
        end
        wr[0] = 1'b0;
        wait_sf(0, 100);
        for (int k = 3; k < 6; k++) begin
            push_exp(0, frame_8n1(cbytes[k]), 10);
            apply_stimulus(0, cbytes[k]);
            @(negedge clk);
            check_output($sformatf("same_edge_full_%0d", k), full[0], (k == 5));
        end
        wr[0] = 1'b0;
        wait_idle(0, 400);

        // Reset during a data bit with a second byte still queued
        push_exp(0, frame_8n1(8'hA5), 10);
        push_exp(0, frame_8n1(8'h5A), 10);
        apply_stimulus(0, 8'hA5);
        @(negedge clk);
        apply_stimulus(0, 8'h5A);
        @(negedge clk);
        wr[0] = 1'b0;
        repeat (5) @(negedge clk);
        s_sf = sf_cnt[0];
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_tx", tx[0], 1);
        check_output("midreset_busy", busy[0], 0);
        check_output("midreset_sf", sf[0], 0);
        check_output("midreset_full", full[0], 0);
        check_output("midreset_ovf", ovf[0], 0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) lows = lows + 1;
        end
        check_output("post_reset_quiet", lows, 0);
        check_output("post_reset_no_sf", sf_cnt[0] - s_sf, 0);
        s_sf = sf_cnt[0];
        push_exp(0, frame_8n1(8'h3C), 10);
        apply_stimulus(0, 8'h3C);
        @(negedge clk);
        wr[0] = 1'b0;
        wait_idle(0, 100);
        check_output("post_reset_one_frame", sf_cnt[0] - s_sf, 1);

        repeat (5) @(negedge clk);
        check_output("q0_drained", q0.size(), 0);
        check_output("q1_drained", q1.size(), 0);
        check_output("q2_drained", q2.size(), 0);
        check_output("q3_drained", q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
